// File: rtl/axi_pkg.sv
// axi_pkg: AXI response codes and the axi_lite_master state encoding.
// S_DRAIN exists only when AXI_LITE_MASTER_TIMEOUT_EN is defined.
package axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef logic [2:0] mstate_t;

    localparam mstate_t S_IDLE  = 3'd0;
    localparam mstate_t S_WRITE = 3'd1;
    localparam mstate_t S_WRESP = 3'd2;
    localparam mstate_t S_RADDR = 3'd3;
    localparam mstate_t S_RDATA = 3'd4;
    localparam mstate_t S_RESP  = 3'd5;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam mstate_t S_DRAIN = 3'd6;
`endif

endpackage

// File: rtl/axi_intf.sv
// axi_intf: AXI4-Lite channel bundle with an initiator-side modport.
interface axi_intf
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    aclk;
    logic                    aresetn;
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    resp_t                   bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    resp_t                   rresp;

    modport master (
        output aclk, aresetn,
        output awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot,
        output rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_master.sv
// axi_lite_master: turns one outstanding CPU load/store into an AXI4-Lite transaction.
// Define AXI_LITE_MASTER_TIMEOUT_EN to add a watchdog that forces an error response and drains the bus.
module axi_lite_master
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    axi_intf.master                 axi
);

    mstate_t                 state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    draining;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ar_done_q, ar_done_d;
    logic          resp_done_q, resp_done_d;
    logic          tmo_q, tmo_d;
    logic          busy;

    // After a timeout, handshakes left open must still be finished so the slave is not stranded
    assign busy        = state_q inside {S_WRITE, S_WRESP, S_RADDR, S_RDATA};
    assign draining    = tmo_q && (state_q == S_RESP || state_q == S_DRAIN);
    assign axi.arvalid = !we_q && !ar_done_q && (state_q == S_RADDR || draining);
    assign axi.bready  = we_q && (state_q == S_WRESP || (draining && !resp_done_q));
    assign axi.rready  = !we_q && (state_q == S_RDATA || (draining && !resp_done_q));
`else
    assign draining    = 1'b0;
    assign axi.arvalid = state_q == S_RADDR;
    assign axi.bready  = state_q == S_WRESP;
    assign axi.rready  = state_q == S_RDATA;
`endif

    assign axi.aclk    = aclk;
    assign axi.aresetn = aresetn;
    assign axi.awvalid = we_q && !aw_done_q && (state_q == S_WRITE || draining);
    assign axi.wvalid  = we_q && !w_done_q && (state_q == S_WRITE || draining);
    assign axi.awaddr  = addr_q;
    assign axi.araddr  = addr_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.awprot  = 3'b000;
    assign axi.arprot  = 3'b000;

    assign req_ready = aresetn && state_q == S_IDLE;
    assign rsp_valid = state_q == S_RESP;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // Next state, request capture and response capture
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q || (axi.awvalid && axi.awready);
        w_done_d    = w_done_q || (axi.wvalid && axi.wready);
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        ar_done_d   = ar_done_q || (axi.arvalid && axi.arready);
        resp_done_d = resp_done_q || (axi.bvalid && axi.bready) || (axi.rvalid && axi.rready);
        tmo_d       = tmo_q;
`endif
        case (state_q)
            S_IDLE: if (req_valid) begin
                state_d     = req_we ? S_WRITE : S_RADDR;
                we_d        = req_we;
                addr_d      = req_addr;
                wdata_d     = req_wdata;
                wstrb_d     = req_wstrb;
                aw_done_d   = 1'b0;
                w_done_d    = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
                ar_done_d   = 1'b0;
                resp_done_d = 1'b0;
                tmo_d       = 1'b0;
`endif
            end
            S_WRITE: if (aw_done_d && w_done_d) state_d = S_WRESP;
            S_WRESP: if (axi.bvalid) begin
                rsp_err_d = axi.bresp != OKAY;
                state_d   = S_RESP;
            end
            S_RADDR: if (axi.arready) state_d = S_RDATA;
            S_RDATA: if (axi.rvalid) begin
                rsp_rdata_d = axi.rdata;
                rsp_err_d   = axi.rresp != OKAY;
                state_d     = S_RESP;
            end
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
            S_RESP:  state_d = (tmo_q && !resp_done_d) ? S_DRAIN : S_IDLE;
            S_DRAIN: if (resp_done_d) state_d = S_IDLE;
`else
            S_RESP:  state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        if (busy && cnt_q == TO_LAST && state_d == state_q) begin
            state_d     = S_RESP;
            tmo_d       = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end
        cnt_d = (state_d != state_q) ? '0 : (busy ? cnt_q + CW'(1) : cnt_q);
`endif
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            ar_done_q   <= 1'b0;
            resp_done_q <= 1'b0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            ar_done_q   <= ar_done_d;
            resp_done_q <= resp_done_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed bench for axi_lite_master with a small AXI4-Lite slave model.
// The timeout scenario runs only when AXI_LITE_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_master;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        req_valid, req_we;
    logic        req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    axi_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .aclk      (clk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .axi       (axi)
    );

    always #5 clk = ~clk;

    // slave configuration
    int    aw_wait = 0;
    int    w_wait  = 0;
    logic  aw_stall = 1'b0;
    logic  r_stall  = 1'b0;
    resp_t b_cfg = OKAY;
    resp_t r_cfg = OKAY;

    // slave state
    logic        aw_got, w_got, b_pend, r_pend;
    int          aw_cnt, w_cnt;
    logic [31:0] got_addr, got_data;
    logic [3:0]  got_strb;
    logic [31:0] mem = 32'h0;
    logic [31:0] rdata_r;
    resp_t       bresp_r, rresp_r;
    logic [31:0] last_awaddr = 32'h0;
    logic [31:0] last_wdata  = 32'h0;

    // monitors
    int   cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
    int   b_cnt = 0, rsp_cnt = 0, viol = 0, w_extra = 0;
    logic aw_prev = 1'b0, w_prev = 1'b0, ar_prev = 1'b0;

    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] wa, wd;
    logic [3:0]  ws;

    assign axi.awready = axi.awvalid && !aw_got && aw_cnt >= aw_wait && !aw_stall;
    assign axi.wready  = axi.wvalid && !w_got && w_cnt >= w_wait;
    assign axi.arready = axi.arvalid && !r_pend;
    assign axi.bvalid  = b_pend;
    assign axi.bresp   = bresp_r;
    assign axi.rvalid  = r_pend && !r_stall;
    assign axi.rdata   = rdata_r;
    assign axi.rresp   = rresp_r;

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;
    assign wa    = aw_hs ? axi.awaddr : got_addr;
    assign wd    = w_hs ? axi.wdata : got_data;
    assign ws    = w_hs ? axi.wstrb : got_strb;

    // slave: single word register at 0xFF (low nibble = LEDs), 0xDEADBEEF elsewhere
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            b_pend <= 1'b0;
            r_pend <= 1'b0;
            aw_cnt <= 0;
            w_cnt  <= 0;
        end else begin
            aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
            if (aw_hs) begin
                aw_got      <= 1'b1;
                got_addr    <= axi.awaddr;
                last_awaddr <= axi.awaddr;
                aw_hs_cyc   <= cyc;
            end
            if (w_hs) begin
                w_got      <= 1'b1;
                got_data   <= axi.wdata;
                got_strb   <= axi.wstrb;
                last_wdata <= axi.wdata;
                w_hs_cyc   <= cyc;
            end
            if ((aw_got || aw_hs) && (w_got || w_hs) && !b_pend) begin
                b_pend  <= 1'b1;
                bresp_r <= b_cfg;
                if (wa == 32'hFF && b_cfg == OKAY)
                    for (int i = 0; i < 4; i++)
                        if (ws[i]) mem[8*i +: 8] <= wd[8*i +: 8];
            end
            if (axi.bvalid && axi.bready) begin
                b_pend <= 1'b0;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_cnt  <= b_cnt + 1;
            end
            if (ar_hs) begin
                r_pend  <= 1'b1;
                rdata_r <= (axi.araddr == 32'hFF) ? mem : 32'hDEAD_BEEF;
                rresp_r <= r_cfg;
            end
            if (axi.rvalid && axi.rready) r_pend <= 1'b0;
        end
    end

    // protocol monitor: valid dropping before handshake, W valid after its handshake, response pulses
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (axi.wvalid && w_got) w_extra <= w_extra + 1;
        if (aresetn && ((aw_prev && !axi.awvalid) || (w_prev && !axi.wvalid) || (ar_prev && !axi.arvalid)))
            viol <= viol + 1;
        aw_prev <= aresetn && axi.awvalid && !axi.awready;
        w_prev  <= aresetn && axi.wvalid && !axi.wready;
        ar_prev <= aresetn && axi.arvalid && !axi.arready;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // lat counts the acceptance cycle as cycle 1 and returns the cycle holding rsp_valid
    task automatic xfer(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output int lat, output logic err, output logic [31:0] rdata);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_busy"}, req_ready, 0);
        lat = 2;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_rsp"}, rsp_valid, 1);
        err   = rsp_err;
        rdata = rsp_rdata;
        @(negedge clk);
        check({tag, "_pulse"}, rsp_valid, 0);
    endtask

    initial begin
        int          lat, b0, r0, n;
        logic        err;
        logic [31:0] rd;
        aresetn   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid, rsp_err, req_ready}, 0);
        check("rst_rdata", rsp_rdata, 0);
        aresetn = 1'b1;
        @(negedge clk);
        check("idle_ready", req_ready, 1);

        xfer("wr_led", 1'b1, 32'hFF, 32'h5, 4'hF, lat, err, rd);
        check("wr_lat", lat, 4);
        check("wr_err", err, 0);
        check("wr_rdata", rd, 0);
        check("wr_awaddr", last_awaddr, 32'hFF);
        check("wr_wdata", last_wdata, 32'h5);
        check("led", {28'h0, mem[3:0]}, 32'h5);
        check("prot", {26'h0, axi.awprot, axi.arprot}, 0);
        check("ready_after", req_ready, 1);

        xfer("rd_led", 1'b0, 32'hFF, 32'h0, 4'h0, lat, err, rd);
        check("rd_lat", lat, 4);
        check("rd_err", err, 0);
        check("rd_data", rd, 32'h5);

        b_cfg = SLVERR;
        xfer("wr_slverr", 1'b1, 32'hFF, 32'hFFFF_FFFF, 4'hF, lat, err, rd);
        b_cfg = OKAY;
        check("slverr_err", err, 1);
        check("slverr_rdata", rd, 0);

        r_cfg = DECERR;
        xfer("rd_decerr", 1'b0, 32'h44, 32'h0, 4'h0, lat, err, rd);
        r_cfg = OKAY;
        check("decerr_err", err, 1);

        aw_wait = 3;
        b0 = b_cnt;
        r0 = rsp_cnt;
        xfer("wr_wfirst", 1'b1, 32'hFF, 32'h9, 4'h1, lat, err, rd);
        aw_wait = 0;
        check("wfirst_lat", lat, 7);
        check("wfirst_gap", aw_hs_cyc - w_hs_cyc, 3);
        check("wfirst_b", b_cnt - b0, 1);
        check("wfirst_rsp", rsp_cnt - r0, 1);
        check("wfirst_err", err, 0);
        check("led_wfirst", {28'h0, mem[3:0]}, 32'h9);

        xfer("wr_byte1", 1'b1, 32'hFF, 32'h0000_AB00, 4'h2, lat, err, rd);
        check("byte1_err", err, 0);
        xfer("rd_merge", 1'b0, 32'hFF, 32'h0, 4'h0, lat, err, rd);
        check("merge_data", rd, 32'h0000_AB09);
        xfer("rd_other", 1'b0, 32'h40, 32'h0, 4'h0, lat, err, rd);
        check("other_data", rd, 32'hDEAD_BEEF);
        check("other_err", err, 0);

        r_stall = 1'b1;
        r0 = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'hFF;
        check("rrst_accept", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rrst_rdata_state", {30'h0, axi.arvalid, axi.rready}, 32'h1);
        #1 aresetn = 1'b0;
        #1;
        check("rrst_async", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid, req_ready}, 0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        r_stall = 1'b0;
        @(negedge clk);
        check("rrst_norsp", rsp_cnt - r0, 0);
        xfer("rd_after_rst", 1'b0, 32'hFF, 32'h0, 4'h0, lat, err, rd);
        check("after_rst_lat", lat, 4);
        check("after_rst_data", rd, 32'h0000_AB09);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        aw_stall = 1'b1;
        b0 = b_cnt;
        r0 = rsp_cnt;
        xfer("wr_tmo", 1'b1, 32'h80, 32'h1234, 4'hF, lat, err, rd);
        check("tmo_lat", lat, 18);
        check("tmo_err", err, 1);
        check("tmo_rdata", rd, 0);
        check("drain_ready", req_ready, 0);
        check("drain_aw", axi.awvalid, 1);
        repeat (3) @(negedge clk);
        check("drain_hold", req_ready, 0);
        aw_stall = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", req_ready, 1);
        check("drain_b", b_cnt - b0, 1);
        check("drain_rsp", rsp_cnt - r0, 1);
`endif

        check("no_valid_drop", viol, 0);
        check("w_after_hs", w_extra, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Initiator end of the AXI4-Lite bus: converts a single-outstanding CPU load/store request into AXI4-Lite read or write transactions on an axi_intf master modport.
- Sits between the core's data-memory port and the peripheral interconnect, which carries the LED, UART and timer slaves.
- Returns read data or an error flag to the core as a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and awaddr/araddr
- DATA_WIDTH, 32, width of req_wdata, rsp_rdata and wdata/rdata
- TIMEOUT_CYCLES, 255, watchdog limit; used only with AXI_LITE_MASTER_TIMEOUT_EN

Ports:
- aclk  in  1  clock; drives all state
- aresetn  in  1  reset, asynchronous, active-low
- req_valid  in  1  CPU request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data
- req_wstrb  in  DATA_WIDTH/8  byte enables
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  response was not OKAY, or timed out
- axi  modport  axi_intf.master  AW/W/B/AR/R channels; axi.aclk and axi.aresetn are tied to aclk and aresetn at top

Behaviour:
- Reset (aresetn low, asynchronous):
  - FSM goes to IDLE.
  - awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err = 0.
  - rsp_rdata = 0. req_ready = 0 while reset is asserted.
  - Reset mid-transaction abandons it without a response.
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, register addr, wdata, wstrb and we.
  - Go to WRITE if we = 1, else RADDR.
- WRITE:
  - awvalid and wvalid are asserted in the cycle after acceptance.
  - Two internal flags, aw_done and w_done, track each channel independently.
  - Each valid deasserts in the cycle after its own handshake.
  - The slave may accept AW and W in any order or in the same cycle.
  - When both flags are set, go to WRESP.
- WRESP:
  - bready = 1.
  - On bvalid, capture rsp_err = (bresp != OKAY) and go to RESP.
- RADDR:
  - arvalid = 1.
  - On arready, go to RDATA.
- RDATA:
  - rready = 1.
  - On rvalid, capture rdata into rsp_rdata and rsp_err = (rresp != OKAY), then go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then IDLE.
  - The core must take the response; there is no back-pressure.
- Protocol rules:
  - No valid drops before its handshake completes.
  - Address, data and strobe stay stable while the corresponding valid is high.
  - awprot and arprot = 0.
  - bvalid or rvalid arriving outside the matching state is ignored, because bready and rready are low there.
- Minimum latency with a zero-wait slave:
  - Write: acceptance → rsp_valid in 4 cycles.
  - Read: acceptance → rsp_valid in 4 cycles.
- Maximum one transaction outstanding; req_ready stays low from acceptance until the cycle after rsp_valid.

Optional Feature:
- Macro: AXI_LITE_MASTER_TIMEOUT_EN.
- With the macro:
  - An 8-bit-minimum counter runs in WRITE, WRESP, RADDR and RDATA.
  - The counter is cleared on every state entry.
  - Reaching TIMEOUT_CYCLES forces RESP with rsp_err = 1 and rsp_rdata = 0.
  - The FSM then enters DRAIN, not IDLE. DRAIN keeps pending valids high and bready/rready high until the outstanding handshakes finish, discarding the results.
  - req_ready stays 0 during DRAIN.
- Without the macro: no counter and no DRAIN state; the master waits indefinitely.

Decomposition:
- axi_pkg holds:
  - the resp_t enum: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11
  - the master state enum
- No sub-module: FSM and datapath registers stay in one file.
- The timeout counter is inline, under the macro guard.

Test Plan:
- Write 0x0000_00FF, data 0x0000_0005, wstrb 0xF, to a zero-wait LED slave → awaddr = 0xFF, wdata = 0x5; rsp_valid 4 cycles after acceptance; rsp_err = 0; LED slave shows 4'b0101.
- Read 0x0000_00FF after that write → arvalid until arready, rready high; rsp_rdata = 0x0000_0005; rsp_err = 0.
- Slave accepts W 3 cycles before AW → wvalid drops after its handshake, awvalid held until accepted; exactly one B accepted; single rsp_valid.
- Slave returns bresp = SLVERR, then rresp = DECERR on a following read → rsp_err = 1 on both responses; rsp_rdata = 0 for the write.
- aresetn pulsed low while in RDATA with arvalid already accepted → all valids and readies 0 immediately; no rsp_valid; next request accepted normally after release.
- With AXI_LITE_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave never asserts awready → rsp_valid with rsp_err = 1 after 16 stalled cycles; req_ready stays 0 until awready and bvalid finally complete.
